// File: rtl/pe_ctrl_pkg.sv
// Shared definitions for the PE control sequencer: control-word layout, select and opcode
// encodings, the packed control-word struct, FSM state constants and a reserved-field helper.
package pe_ctrl_pkg;

  localparam int PE_CTRL_W = 11;
  localparam int PE_HOLD_W = 4;
  localparam int SEL_BITS  = 3;
  localparam int OPC_BITS  = 2;

  localparam int OUT_LSB = 8;
  localparam int OP1_LSB = 5;
  localparam int OP2_LSB = 2;
  localparam int OPC_LSB = 0;

  typedef logic [SEL_BITS-1:0] sel_t;

  localparam sel_t SEL_E    = 3'b000;
  localparam sel_t SEL_S    = 3'b001;
  localparam sel_t SEL_W    = 3'b010;
  localparam sel_t SEL_N    = 3'b011;
  localparam sel_t SEL_DMEM = 3'b100;
  localparam sel_t SEL_REG1 = 3'b101;
  localparam sel_t SEL_REG2 = 3'b110;
  localparam sel_t SEL_RSVD = 3'b111;

  typedef enum logic [OPC_BITS-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } pe_opcode_e;

  typedef struct packed {
    sel_t       out_sel;
    sel_t       op1;
    sel_t       op2;
    pe_opcode_e opcode;
  } pe_ctrl_t;

  typedef logic [1:0] pe_state_t;

  localparam pe_state_t ST_IDLE = 2'd0;
  localparam pe_state_t ST_RUN  = 2'd1;
  localparam pe_state_t ST_DONE = 2'd2;

  function automatic logic has_rsvd(input pe_ctrl_t w);
    return (w.out_sel == SEL_RSVD) || (w.op1 == SEL_RSVD) || (w.op2 == SEL_RSVD);
  endfunction

endpackage

// File: rtl/pe_ctrl_ctx_mem.sv
// Context memory for the PE sequencer: one synchronous write port, one combinational read port.
// Contents are deliberately not reset so a programmed context survives a sequencer reset.
module pe_ctrl_ctx_mem
  import pe_ctrl_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int W     = PE_HOLD_W + PE_CTRL_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pe_ctrl_sequencer.sv
// Plays a stored program of PE control words (each held hold+1 cycles) with loop, stall and abort.
// Optional reserved-select checking is enabled by defining PE_CTRL_CHECK_EN.
module pe_ctrl_sequencer
  import pe_ctrl_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH),
  parameter int CTRL_W = PE_CTRL_W,
  parameter int HOLD_W = PE_HOLD_W,
  parameter int LOOP_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [AW-1:0]            cfg_addr,
  input  logic [HOLD_W+CTRL_W-1:0] cfg_data,
  input  logic [AW:0]              prog_len,
  input  logic [LOOP_W-1:0]        loop_cnt,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     stall,
  output logic [CTRL_W-1:0]        ctrl_out,
  output logic                     ctrl_valid,
  output logic                     busy,
  output logic                     done,
  output logic [AW-1:0]            pc,
  output logic                     cfg_err,
  output logic                     illegal_err
);

  localparam int          EW      = HOLD_W + CTRL_W;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  pe_state_t         state;
  logic [HOLD_W-1:0] dwell;
  logic [LOOP_W-1:0] loops;
  logic [AW:0]       len;

  logic              idle;
  logic              wr_en;
  logic              more;
  logic              bad;
  logic [AW:0]       len_clamped;
  logic [AW-1:0]     rd_addr;
  logic [EW-1:0]     mem_q;
  logic [EW-1:0]     entry;
  logic [CTRL_W-1:0] entry_ctrl;
  logic [HOLD_W-1:0] entry_hold;

  assign idle        = (state == ST_IDLE);
  assign busy        = !idle;
  assign wr_en       = cfg_we && idle;
  assign len_clamped = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
  assign more        = (({1'b0, pc} + (AW+1)'(1)) < len);

  // The single read port serves both the start load (entry 0) and the next-entry/loop-restart load.
  assign rd_addr = (idle || !more) ? '0 : pc + AW'(1);

  pe_ctrl_ctx_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (EW)
  ) u_ctx_mem (
    .clk     (clk),
    .we      (wr_en),
    .wr_addr (cfg_addr),
    .wr_data (cfg_data),
    .rd_addr (rd_addr),
    .rd_data (mem_q)
  );

  // A write landing in the same cycle as start must be seen by the very first issued word.
  assign entry      = (wr_en && (cfg_addr == rd_addr)) ? cfg_data : mem_q;
  assign entry_ctrl = entry[CTRL_W-1:0];
  assign entry_hold = entry[EW-1 -: HOLD_W];

`ifdef PE_CTRL_CHECK_EN
  assign bad = has_rsvd(pe_ctrl_t'(entry_ctrl));
`else
  assign bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= '0;
      dwell       <= '0;
      loops       <= '0;
      len         <= '0;
      ctrl_out    <= '0;
      ctrl_valid  <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
      illegal_err <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= cfg_we && !idle;
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            if (len_clamped == '0) begin
              done <= 1'b1;
            end else begin
              len         <= len_clamped;
              loops       <= loop_cnt;
              pc          <= '0;
              illegal_err <= 1'b0;
              if (bad) begin
                illegal_err <= 1'b1;
              end else begin
                ctrl_out   <= entry_ctrl;
                dwell      <= entry_hold;
                ctrl_valid <= 1'b1;
                state      <= ST_RUN;
              end
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            state      <= ST_IDLE;
            ctrl_valid <= 1'b0;
          end else if (!stall) begin
            if (dwell != '0) begin
              dwell <= dwell - HOLD_W'(1);
            end else if (more || (loops != '0)) begin
              if (!more) begin
                loops <= loops - LOOP_W'(1);
              end
              // A rejected word is never issued: playback stops quietly without a done pulse.
              if (bad) begin
                illegal_err <= 1'b1;
                ctrl_valid  <= 1'b0;
                state       <= ST_IDLE;
              end else begin
                pc       <= rd_addr;
                ctrl_out <= entry_ctrl;
                dwell    <= entry_hold;
              end
            end else begin
              state      <= ST_DONE;
              ctrl_valid <= 1'b0;
              done       <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state      <= ST_IDLE;
          ctrl_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
